fetch_unit: RTL

- Instruction-fetch front end directly upstream of the instruction memory and downstream-feeding the decoder.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned instruction word with its PC into a small in-order queue and presents it to decode over a valid/ready handshake.
- Handles stalls (backpressure) and PC redirects (branch/jump) with a queue flush.

---
 rtl/fetch_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program-counter owner and in-order fetch queue feeding decode
//               over a valid/ready handshake, with redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] occupancy
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [31:0]        r_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_q_pc    [DEPTH];
    logic [31:0]        r_q_instr [DEPTH];

    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_unused_rpc_lsb;

    assign w_empty          = (r_count == '0);
    assign w_pop            = ~w_empty & out_ready;
    // A full queue may still accept a fetch when the head leaves the same cycle.
    assign w_push           = fetch_en & ~redirect_valid & ((r_count < c_DEPTH_CNT) | w_pop);
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];

    assign imem_addr = r_pc;
    assign out_valid = ~w_empty;
    assign out_pc    = w_empty ? 32'h0 : r_q_pc[r_head];
    assign out_instr = w_empty ? 32'h0 : r_q_instr[r_head];
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= imem_data;
        end
    end

endmodule
`default_nettype wire
